// File: rtl/mem_stage_ctrl_pkg.sv
// mem_stage_ctrl_pkg: shared M-stage types, field widths and default bus timeout.
package mem_stage_ctrl_pkg;
    localparam int DATA_W = 32;
    localparam int REG_W = 5;
    localparam int TIMEOUT_DEF = 16;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_e;

    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
        logic [DATA_W-1:0] read_data;
        logic [DATA_W-1:0] alu_out;
        logic [REG_W-1:0] write_reg;
        logic align_err;
        logic bus_err;
    } w_fields_t;
endpackage

// File: rtl/mem_stage_ctrl_if.sv
// mem_stage_ctrl_if: data-memory req/ack bus between the M stage (master) and memory (slave).
interface mem_stage_ctrl_if;
    import mem_stage_ctrl_pkg::*;
    logic dmem_req;
    logic dmem_we;
    logic [DATA_W-1:0] dmem_addr;
    logic [DATA_W-1:0] dmem_wdata;
    logic [DATA_W-1:0] dmem_rdata;
    logic dmem_ack;
    modport master (output dmem_req, dmem_we, dmem_addr, dmem_wdata, input dmem_rdata, dmem_ack);
    modport slave (input dmem_req, dmem_we, dmem_addr, dmem_wdata, output dmem_rdata, dmem_ack);
endinterface

// File: rtl/mem_wait_timer.sv
// mem_wait_timer: counts stalled request cycles and flags the last one allowed before abort.
module mem_wait_timer
    import mem_stage_ctrl_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int CNT_W = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc_i,
    output logic tc_o
);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = inc_i ? cnt_q + CNT_W'(1) : '0;
        tc_o = cnt_q == CNT_W'(TIMEOUT - 1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) cnt_q <= '0;
        else cnt_q <= cnt_d;
    end
endmodule

// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: M-stage data-memory access over req/ack, with upstream stall,
// misalignment and timeout reporting, and the M-to-W pipeline register.
module mem_stage_ctrl
    import mem_stage_ctrl_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int CNT_W = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic RegWriteM,
    input  logic MemtoRegM,
    input  logic MemWriteM,
    input  logic [DATA_W-1:0] ALUOutM,
    input  logic [DATA_W-1:0] WriteDataM,
    input  logic [REG_W-1:0] WriteRegM,
    output logic StallM,
    mem_stage_ctrl_if.master bus,
    output logic RegWriteW,
    output logic MemtoRegW,
    output logic [DATA_W-1:0] ReadDataW,
    output logic [DATA_W-1:0] ALUOutW,
    output logic [REG_W-1:0] WriteRegW,
    output logic AlignErrW,
    output logic BusErrW
);
    state_e state_q, state_d;
    w_fields_t w_q, w_d;
    logic access, align, abort, tc;

    mem_wait_timer #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) u_timer (
        .clk  (clk),
        .rst_n(rst_n),
        .inc_i(StallM),
        .tc_o (tc)
    );

    assign bus.dmem_we = MemWriteM;
    assign bus.dmem_addr = {ALUOutM[DATA_W-1:2], 2'b00};
    assign bus.dmem_wdata = WriteDataM;

    // M inputs are frozen while stalled, so WAIT needs no captured copy of them.
    always_comb begin
        access = MemWriteM | MemtoRegM;
        align = (state_q == IDLE) & access & (ALUOutM[1:0] != 2'b00);
        bus.dmem_req = rst_n & ((state_q == WAIT) | (access & !align));
        abort = (state_q == WAIT) & !bus.dmem_ack & tc;
        StallM = bus.dmem_req & !bus.dmem_ack & !abort;
        state_d = StallM ? WAIT : IDLE;
        w_d = w_q;
        w_d.reg_write = !StallM & !align & !abort & RegWriteM;
        w_d.mem_to_reg = !StallM & !align & !abort & MemtoRegM & !MemWriteM;
        w_d.align_err = align;
        w_d.bus_err = abort;
        w_d.alu_out = StallM ? w_q.alu_out : ALUOutM;
        w_d.write_reg = StallM ? w_q.write_reg : WriteRegM;
        w_d.read_data = (bus.dmem_req & bus.dmem_ack & MemtoRegM & !MemWriteM) ? bus.dmem_rdata : w_q.read_data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            w_q <= '0;
        end else begin
            state_q <= state_d;
            w_q <= w_d;
        end
    end

    assign RegWriteW = w_q.reg_write;
    assign MemtoRegW = w_q.mem_to_reg;
    assign ReadDataW = w_q.read_data;
    assign ALUOutW = w_q.alu_out;
    assign WriteRegW = w_q.write_reg;
    assign AlignErrW = w_q.align_err;
    assign BusErrW = w_q.bus_err;
endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb_mem_stage_ctrl: directed and random M-stage accesses checked against a transaction-level model.
module tb_mem_stage_ctrl;
    import mem_stage_ctrl_pkg::*;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic RegWriteM = 1'b0, MemtoRegM = 1'b0, MemWriteM = 1'b0;
    logic [31:0] ALUOutM = '0, WriteDataM = '0;
    logic [4:0] WriteRegM = '0;
    logic StallM, RegWriteW, MemtoRegW, AlignErrW, BusErrW;
    logic [31:0] ReadDataW, ALUOutW;
    logic [4:0] WriteRegW;
    int vectors = 0;
    int miscompares = 0;
    logic [31:0] exp_rd = '0;

    always #5 clk = ~clk;

    mem_stage_ctrl_if bus ();

    mem_stage_ctrl #(.TIMEOUT(TO), .CNT_W(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM), .MemWriteM(MemWriteM),
        .ALUOutM(ALUOutM), .WriteDataM(WriteDataM), .WriteRegM(WriteRegM),
        .StallM(StallM), .bus(bus),
        .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW), .ReadDataW(ReadDataW),
        .ALUOutW(ALUOutW), .WriteRegW(WriteRegW), .AlignErrW(AlignErrW), .BusErrW(BusErrW)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_w_zero(input string tag);
        check({tag, "_regwrite"}, RegWriteW, 0);
        check({tag, "_memtoreg"}, MemtoRegW, 0);
        check({tag, "_readdata"}, ReadDataW, 0);
        check({tag, "_aluout"}, ALUOutW, 0);
        check({tag, "_writereg"}, WriteRegW, 0);
        check({tag, "_alignerr"}, AlignErrW, 0);
        check({tag, "_buserr"}, BusErrW, 0);
    endtask

    // Memory answers in cycle 'delay' of the op regardless of req; delay >= TO means never.
    task automatic run_op(input logic rw, input logic m2r, input logic mw, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] rd, input logic [4:0] wr, input int delay);
        logic access, mis, abort, load_done;
        int last;
        access = mw | m2r;
        mis = access && (a[1:0] != 2'b00);
        last = (!access || mis) ? 0 : (delay < TO ? delay : TO - 1);
        abort = access && !mis && delay >= TO;
        load_done = access && !mis && !abort && m2r && !mw;
        RegWriteM = rw; MemtoRegM = m2r; MemWriteM = mw;
        ALUOutM = a; WriteDataM = wd; WriteRegM = wr;
        for (int c = 0; c <= last; c++) begin
            bus.dmem_ack = (c == delay);
            bus.dmem_rdata = (c == delay) ? rd : $urandom;
            @(negedge clk);
            check("stall", StallM, 32'(c < last));
            check("req", bus.dmem_req, 32'(access && !mis));
            if (access && !mis) begin
                check("we", bus.dmem_we, mw);
                check("addr", bus.dmem_addr, {a[31:2], 2'b00});
                check("wdata", bus.dmem_wdata, wd);
            end
            @(posedge clk);
            #1;
            if (c < last) begin
                check("bubble_regwrite", RegWriteW, 0);
                check("bubble_memtoreg", MemtoRegW, 0);
                check("bubble_alignerr", AlignErrW, 0);
                check("bubble_buserr", BusErrW, 0);
            end
        end
        bus.dmem_ack = 1'b0;
        if (load_done) exp_rd = rd;
        check("w_regwrite", RegWriteW, 32'(rw && !mis && !abort));
        check("w_memtoreg", MemtoRegW, 32'(m2r && !mw && !mis && !abort));
        check("w_readdata", ReadDataW, exp_rd);
        check("w_aluout", ALUOutW, a);
        check("w_writereg", WriteRegW, wr);
        check("w_alignerr", AlignErrW, 32'(mis));
        check("w_buserr", BusErrW, 32'(abort));
    endtask

    initial begin
        bus.dmem_ack = 1'b0;
        bus.dmem_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check_w_zero("reset");
        check("reset_stall", StallM, 0);
        check("reset_req", bus.dmem_req, 0);
        rst_n = 1'b1;

        run_op(1, 0, 0, 32'h0000_0010, 32'h0, 32'h0, 5'd5, 3);
        run_op(1, 1, 0, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 5'd7, 2);
        run_op(0, 0, 1, 32'h0000_0204, 32'h1234_5678, 32'h0, 5'd0, 0);
        run_op(1, 1, 0, 32'h0000_0102, 32'h0, 32'h5555_AAAA, 5'd9, 0);
        run_op(1, 1, 0, 32'h0000_0400, 32'h0, 32'hCAFE_F00D, 5'd3, 100);
        run_op(1, 0, 0, 32'h0000_0044, 32'h0, 32'h0BAD_0BAD, 5'd4, 0);
        run_op(1, 1, 1, 32'h0000_0508, 32'hA5A5_5A5A, 32'h7777_7777, 5'd11, 1);

        RegWriteM = 1'b1; MemtoRegM = 1'b1; MemWriteM = 1'b0;
        ALUOutM = 32'h0000_0300; WriteRegM = 5'd12;
        repeat (3) @(posedge clk);
        #1;
        check("rstwait_req_before", bus.dmem_req, 1);
        check("rstwait_stall_before", StallM, 1);
        rst_n = 1'b0;
        RegWriteM = 1'b0; MemtoRegM = 1'b0; ALUOutM = '0; WriteRegM = '0;
        @(posedge clk);
        #1;
        check("rstwait_req_after", bus.dmem_req, 0);
        check_w_zero("rstwait");
        rst_n = 1'b1;
        bus.dmem_ack = 1'b1;
        bus.dmem_rdata = 32'hBAD0_0BAD;
        @(negedge clk);
        check("lateack_req", bus.dmem_req, 0);
        check("lateack_stall", StallM, 0);
        @(posedge clk);
        #1;
        bus.dmem_ack = 1'b0;
        check_w_zero("lateack");
        exp_rd = '0;

        for (int i = 0; i < 40; i++) begin
            int kind, r, delay;
            logic [31:0] a;
            kind = $urandom_range(0, 3);
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            r = $urandom_range(0, 9);
            delay = r < 6 ? r : (r < 8 ? $urandom_range(6, 15) : $urandom_range(16, 30));
            run_op(1'($urandom_range(0, 1)), kind[0], kind[1], a, $urandom, $urandom,
                   5'($urandom_range(0, 31)), delay);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
